// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: shares one req/gnt/rvalid memory port between the       |
// | instruction-fetch and LSU masters; round-robin with lock, in-order rvalid. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    protocol_err_o
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_WIDTH = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_WIDTH-1:0] C_MAX_CNT  = CNT_WIDTH'(MAX_OUTSTANDING);
  localparam logic [PTR_WIDTH-1:0] C_LAST_PTR = PTR_WIDTH'(MAX_OUTSTANDING - 1);
  localparam logic                 C_OWNER_INSTR = 1'b0;
  localparam logic                 C_OWNER_DATA  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] owner_fifo_q, owner_fifo_d;
  logic [PTR_WIDTH-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;
  logic                       lock_valid_q, lock_valid_d;
  logic                       lock_owner_q, lock_owner_d;
  logic                       rr_last_q, rr_last_d;
  logic                       err_q, err_d;

  logic winner;
  logic can_issue;
  logic mem_req;
  logic push;
  logic pop;
  logic head_owner;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // Arbitration and memory-side request mux.
  always_comb begin
    if (lock_valid_q) begin
      winner = lock_owner_q;
    end else if (instr_req_i && data_req_i) begin
      winner = ~rr_last_q;
    end else begin
      winner = data_req_i ? C_OWNER_DATA : C_OWNER_INSTR;
    end

    can_issue = (count_q < C_MAX_CNT);
    mem_req   = rst_n & can_issue & (instr_req_i | data_req_i);
    push      = mem_req & mem_gnt_i;
    pop       = rst_n & mem_rvalid_i & (count_q != '0);
    head_owner = owner_fifo_q[rd_ptr_q];

    mem_req_o = mem_req;
    if (winner == C_OWNER_DATA) begin
      mem_addr_o  = data_addr_i;
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_wdata_o = data_wdata_i;
    end else begin
      mem_addr_o  = instr_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = {BE_WIDTH{1'b1}};
      mem_wdata_o = '0;
    end

    instr_gnt_o    = push & (winner == C_OWNER_INSTR);
    data_gnt_o     = push & (winner == C_OWNER_DATA);
    instr_rvalid_o = pop & (head_owner == C_OWNER_INSTR);
    data_rvalid_o  = pop & (head_owner == C_OWNER_DATA);
    instr_rdata_o  = mem_rdata_i;
    data_rdata_o   = mem_rdata_i;
    protocol_err_o = err_q;
  end

  // Next-state for owner FIFO, lock, round-robin pointer and error flag.
  always_comb begin
    owner_fifo_d = owner_fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    rr_last_d    = rr_last_q;
    err_d        = err_q;

    if (push) begin
      lock_valid_d = 1'b0;
    end else if (mem_req) begin
      lock_valid_d = 1'b1;
      lock_owner_d = winner;
    end

    if (push) begin
      owner_fifo_d[wr_ptr_q] = winner;
      wr_ptr_d               = ptr_inc(wr_ptr_q);
      rr_last_d              = winner;
    end

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    if (mem_rvalid_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_fifo_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      rr_last_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      owner_fifo_q <= owner_fifo_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      rr_last_q    <= rr_last_d;
      err_q        <= err_d;
    end
  end

endmodule
`default_nettype wire
